// File: rtl/line_buffer_window_ctrl_pkg.sv
// Shared definitions for the line-buffer window controller and the window-consuming kernels:
// control FSM encoding and the window bit-index helper.
package line_buffer_window_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Window bit r*n+c; r=0 is the oldest (top) row, c=0 the oldest (left) column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/line_buffer_window_ctrl_window_shift_reg.sv
// n x n window register: each load shifts every row one column left and drops the new
// column into the rightmost position.
module line_buffer_window_ctrl_window_shift_reg
  import line_buffer_window_ctrl_pkg::*;
#(
  parameter int unsigned WindowSize = 3
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_load,
  input  logic [WindowSize-1:0]            i_column,
  output logic [WindowSize*WindowSize-1:0] o_window
);

  logic [WindowSize*WindowSize-1:0] r_window;
  logic [WindowSize*WindowSize-1:0] w_window_next;

  for (genvar r = 0; r < WindowSize; r++) begin : g_row
    for (genvar c = 0; c < WindowSize; c++) begin : g_col
      localparam int unsigned Idx = win_idx(r, c, WindowSize);
      if (c == WindowSize - 1) begin : g_new
        assign w_window_next[Idx] = i_load ? i_column[r] : r_window[Idx];
      end else begin : g_shift
        localparam int unsigned SrcIdx = win_idx(r, c + 1, WindowSize);
        assign w_window_next[Idx] = i_load ? r_window[SrcIdx] : r_window[Idx];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_window <= '0;
    end else begin
      r_window <= w_window_next;
    end
  end

  assign o_window = r_window;

endmodule

// File: rtl/line_buffer_window_ctrl.sv
// Raster-stream line-buffer controller assembling a registered WindowSize x WindowSize window.
// Optional macro WINDOW_OUT_REG_EN adds one output register stage (window latency 2 cycles).
module line_buffer_window_ctrl
  import line_buffer_window_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth   = 3,
  parameter int unsigned ImageWidth  = 7,
  parameter int unsigned ImageHeight = 7,
  parameter int unsigned RowWidth    = 3,
  parameter int unsigned WindowSize  = 3
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic                             i_in_pixel,
  output logic                             o_lb_write_enable,
  output logic [AddrWidth-1:0]             o_lb_addr,
  output logic                             o_lb_data,
  input  logic [WindowSize-2:0]            i_lb_line_data,
  output logic [WindowSize*WindowSize-1:0] o_window,
  output logic                             o_window_valid,
  output logic [RowWidth-1:0]              o_window_row,
  output logic [AddrWidth-1:0]             o_window_col,
  output logic                             o_frame_done,
  output logic                             o_busy
);

  localparam logic [AddrWidth-1:0] LastCol     = AddrWidth'(ImageWidth - 1);
  localparam logic [RowWidth-1:0]  LastRow     = RowWidth'(ImageHeight - 1);
  localparam logic [AddrWidth-1:0] FirstWinCol = AddrWidth'(WindowSize - 1);
  localparam logic [RowWidth-1:0]  FirstWinRow = RowWidth'(WindowSize - 1);

  state_e                           r_state;
  state_e                           w_state_next;
  logic [AddrWidth-1:0]             r_col;
  logic [AddrWidth-1:0]             w_col_next;
  logic [RowWidth-1:0]              r_row;
  logic [RowWidth-1:0]              w_row_next;
  logic                             w_accept;
  logic                             w_last_pixel;
  logic                             w_win_hit;
  logic [WindowSize-1:0]            w_col_vec;
  logic [WindowSize*WindowSize-1:0] w_shift_window;
  logic                             r_win_valid;
  logic [RowWidth-1:0]              r_win_row;
  logic [AddrWidth-1:0]             r_win_col;
  logic                             r_frame_done;

  assign w_accept     = i_in_valid & (r_state == StRun);
  assign w_last_pixel = (r_col == LastCol) && (r_row == LastRow);
  // Rows/columns before n-1 would mix in stale or previous-line data, so they never fire.
  assign w_win_hit    = w_accept && (r_row >= FirstWinRow) && (r_col >= FirstWinCol);

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StRun;
          w_col_next   = '0;
          w_row_next   = '0;
        end
      end
      StRun: begin
        if (w_accept) begin
          if (w_last_pixel) begin
            w_state_next = StDone;
            w_col_next   = '0;
            w_row_next   = '0;
          end else if (r_col == LastCol) begin
            w_col_next = '0;
            w_row_next = r_row + 1'b1;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_col        <= w_col_next;
      r_row        <= w_row_next;
      r_win_valid  <= w_win_hit;
      r_frame_done <= w_accept & w_last_pixel;
      if (w_win_hit) begin
        r_win_row <= r_row;
        r_win_col <= r_col;
      end
    end
  end

  // Bottom window row is the live pixel; line-buffer bit k is image row (row-1-k).
  assign w_col_vec[WindowSize-1] = i_in_pixel;
  for (genvar k = 0; k < WindowSize - 1; k++) begin : g_lb
    assign w_col_vec[WindowSize-2-k] = i_lb_line_data[k];
  end

  line_buffer_window_ctrl_window_shift_reg #(
    .WindowSize (WindowSize)
  ) u_window_shift_reg (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_load    (w_accept),
    .i_column  (w_col_vec),
    .o_window  (w_shift_window)
  );

  assign o_in_ready        = (r_state == StRun);
  assign o_lb_write_enable = w_accept;
  assign o_lb_addr         = r_col;
  assign o_lb_data         = i_in_pixel;
  assign o_busy            = (r_state == StRun) || (r_state == StDone);

`ifdef WINDOW_OUT_REG_EN
  logic [WindowSize*WindowSize-1:0] r_out_window;
  logic                             r_out_valid;
  logic [RowWidth-1:0]              r_out_row;
  logic [AddrWidth-1:0]             r_out_col;
  logic                             r_out_frame_done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_window     <= '0;
      r_out_valid      <= 1'b0;
      r_out_row        <= '0;
      r_out_col        <= '0;
      r_out_frame_done <= 1'b0;
    end else begin
      r_out_window     <= w_shift_window;
      r_out_valid      <= r_win_valid;
      r_out_row        <= r_win_row;
      r_out_col        <= r_win_col;
      r_out_frame_done <= r_frame_done;
    end
  end

  assign o_window       = r_out_window;
  assign o_window_valid = r_out_valid;
  assign o_window_row   = r_out_row;
  assign o_window_col   = r_out_col;
  assign o_frame_done   = r_out_frame_done;
`else
  assign o_window       = w_shift_window;
  assign o_window_valid = r_win_valid;
  assign o_window_row   = r_win_row;
  assign o_window_col   = r_win_col;
  assign o_frame_done   = r_frame_done;
`endif

endmodule
